// File: rtl/chess_pkg.sv
// Shared chess types: piece codes, square/history types and the opening position.
package chess_pkg;

  // Piece code = {black, type[2:0]}; 0 means an empty square
  localparam logic [2:0] PT_PAWN   = 3'd1;
  localparam logic [2:0] PT_KNIGHT = 3'd2;
  localparam logic [2:0] PT_BISHOP = 3'd3;
  localparam logic [2:0] PT_ROOK   = 3'd4;
  localparam logic [2:0] PT_QUEEN  = 3'd5;
  localparam logic [2:0] PT_KING   = 3'd6;
  localparam logic [3:0] PC_EMPTY  = 4'd0;

  typedef logic [5:0] square_t;

  typedef struct packed {
    square_t    start;
    square_t    end_sq;
    logic [3:0] captured;
    logic       promo;
  } hist_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMMIT, S_RESP} state_t;

  // Square 0 (a1) is the low nibble, square 63 (h8) the high nibble
  localparam logic [255:0] INIT_BOARD =
    256'hCABEDBAC_99999999_00000000_00000000_00000000_00000000_11111111_42365324;

endpackage

// File: rtl/move_history.sv
// LIFO of applied moves; push is ignored when full, pop when empty.
module move_history
  import chess_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  hist_entry_t                  push_data_i,
  input  logic                         pop_i,
  output hist_entry_t                  top_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] top_idx;
  hist_entry_t   mem_q [DEPTH];

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_idx = cnt_q - CW'(1);
  assign top_o   = mem_q[top_idx[AW-1:0]];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o)      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !empty_o) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Entry storage needs no reset: only slots below cnt_q are ever read
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[cnt_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/make_move.sv
// Chess board register file with move/undo FSM (IDLE->FETCH->COMMIT->RESP).
// Optional macro PROMOTION_EN: pawns reaching the last rank become queens.
module make_move
  import chess_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       move_valid,
  input  logic [5:0]                 move_start,
  input  logic [5:0]                 move_end,
  input  logic                       undo_valid,
  output logic                       ready,
  output logic                       done,
  output logic                       err,
  output logic [3:0]                 captured,
  output logic [$clog2(DEPTH+1)-1:0] depth_count,
  output logic [255:0]               board_flat
);
  state_t            state_q;
  logic              is_undo_q, fail_q, done_q, err_q;
  square_t           src_q, dst_q;
  logic [3:0]        mover_q, victim_q, captured_q;
  hist_entry_t       ent_q;
  logic [63:0][3:0]  board_q;

  logic              h_push, h_pop, h_full, h_empty, commit_ok, promo;
  hist_entry_t       h_top, h_wdata;
  logic [3:0]        placed;

`ifdef PROMOTION_EN
  assign promo = (mover_q[2:0] == PT_PAWN) &&
                 ((!mover_q[3] && dst_q[5:3] == 3'd7) || (mover_q[3] && dst_q[5:3] == 3'd0));
`else
  assign promo = 1'b0;
`endif

  assign placed    = promo ? {mover_q[3], PT_QUEEN} : mover_q;
  assign commit_ok = (state_q == S_COMMIT) && !fail_q;
  assign h_push    = commit_ok && !is_undo_q;
  assign h_pop     = commit_ok && is_undo_q;
  assign h_wdata   = '{start: src_q, end_sq: dst_q, captured: victim_q, promo: promo};

  move_history #(.DEPTH(DEPTH)) u_hist (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (h_push),
    .push_data_i (h_wdata),
    .pop_i       (h_pop),
    .top_o       (h_top),
    .count_o     (depth_count),
    .full_o      (h_full),
    .empty_o     (h_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_undo_q  <= 1'b0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      mover_q    <= '0;
      victim_q   <= '0;
      captured_q <= '0;
      ent_q      <= '0;
      board_q    <= INIT_BOARD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (undo_valid) begin
            is_undo_q <= 1'b1;
            state_q   <= S_FETCH;
          end else if (move_valid) begin
            is_undo_q <= 1'b0;
            src_q     <= move_start;
            dst_q     <= move_end;
            mover_q   <= board_q[move_start];
            victim_q  <= board_q[move_end];
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          ent_q   <= h_top;
          fail_q  <= is_undo_q ? h_empty
                               : (mover_q == PC_EMPTY) || (src_q == dst_q) || h_full;
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          if (!fail_q) begin
            if (is_undo_q) begin
              // A promoted queen goes back as the pawn it started as
              board_q[ent_q.start]  <= ent_q.promo ? {board_q[ent_q.end_sq][3], PT_PAWN}
                                                   : board_q[ent_q.end_sq];
              board_q[ent_q.end_sq] <= ent_q.captured;
              captured_q            <= '0;
            end else begin
              board_q[dst_q] <= placed;
              board_q[src_q] <= PC_EMPTY;
              captured_q     <= victim_q;
            end
          end
          done_q  <= !fail_q;
          err_q   <= fail_q;
          state_q <= S_RESP;
        end
        default: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign captured   = captured_q;
  assign board_flat = board_q;

endmodule

// File: tb/tb_make_move.sv
// Self-checking bench for make_move: directed scenarios plus random moves/undos vs. an array model.
module tb_make_move;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef PROMOTION_EN
  localparam bit PROMO = 1'b1;
`else
  localparam bit PROMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          move_valid, undo_valid, ready, done, err;
  logic [5:0]    move_start, move_end;
  logic [3:0]    captured;
  logic [CW-1:0] depth_count;
  logic [255:0]  board_flat;

  int checks = 0;
  int failures = 0;

  typedef struct {int s; int e; int cap; bit promo;} ent_t;
  int   mb[64];
  ent_t mh[$];
  int   mcap;

  make_move #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_start(move_start),
    .move_end(move_end), .undo_valid(undo_valid), .ready(ready), .done(done),
    .err(err), .captured(captured), .depth_count(depth_count), .board_flat(board_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mflat();
    logic [255:0] r;
    for (int i = 0; i < 64; i++) r[4*i +: 4] = 4'(mb[i]);
    return r;
  endfunction

  task automatic model_reset();
    int r0[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int r7[8] = '{12, 10, 11, 13, 14, 11, 10, 12};
    for (int i = 0; i < 64; i++) mb[i] = 0;
    for (int f = 0; f < 8; f++) begin
      mb[f] = r0[f]; mb[8+f] = 1; mb[48+f] = 9; mb[56+f] = r7[f];
    end
    mh.delete();
    mcap = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Apply an operation to the model, drive it into the DUT, and compare the response
  task automatic do_op(input string tag, input bit undo, input bit mv, input int s, input int e);
    bit   exp_err;
    int   lat, p;
    ent_t en;
    exp_err = 1'b0;
    if (undo) begin
      if (mh.size() == 0) exp_err = 1'b1;
      else begin
        en = mh.pop_back();
        p = mb[en.e];
        mb[en.s] = en.promo ? ((p & 8) | 1) : p;
        mb[en.e] = en.cap;
        mcap = 0;
      end
    end else begin
      p = mb[s];
      if (p == 0 || s == e || mh.size() == DEPTH) exp_err = 1'b1;
      else begin
        en.s = s; en.e = e; en.cap = mb[e];
        en.promo = PROMO && ((p & 7) == 1) && ((p < 8 && e / 8 == 7) || (p >= 8 && e / 8 == 0));
        mh.push_back(en);
        mcap = mb[e];
        mb[e] = en.promo ? ((p & 8) | 5) : p;
        mb[s] = 0;
      end
    end
    @(negedge clk);
    chk({tag, ".ready"}, 256'(ready), 256'(1));
    move_valid = mv; undo_valid = undo; move_start = 6'(s); move_end = 6'(e);
    @(negedge clk);
    move_valid = 1'b0; undo_valid = 1'b0;
    lat = 1;
    while (!(done || err) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"},   256'(lat), 256'(3));
    chk({tag, ".done"},  256'(done), 256'(!exp_err));
    chk({tag, ".err"},   256'(err), 256'(exp_err));
    chk({tag, ".board"}, board_flat, mflat());
    chk({tag, ".cap"},   256'(captured), 256'(mcap));
    chk({tag, ".depth"}, 256'(depth_count), 256'(mh.size()));
    @(negedge clk);
    chk({tag, ".pulse"}, 256'({done, err}), 256'(0));
  endtask

  initial begin
    int s, e;
    rst = 1'b1; move_valid = 1'b0; undo_valid = 1'b0; move_start = '0; move_end = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.sq12",  256'(board_flat[51:48]), 256'(1));
    chk("rst.depth", 256'(depth_count), 256'(0));
    chk("rst.board", board_flat, mflat());
    chk("rst.out",   256'({done, err, captured}), 256'(0));

    do_op("undo_empty", 1, 0, 0, 0);
    do_op("empty_sq",   0, 1, 20, 36);
    do_op("same_sq",    0, 1, 12, 12);
    do_op("e2e4",       0, 1, 12, 28);
    do_op("capture",    0, 1, 28, 51);
    do_op("undo_cap",   1, 0, 0, 0);
    chk("undo.sq28", 256'(board_flat[115:112]), 256'(1));
    chk("undo.sq51", 256'(board_flat[207:204]), 256'(9));

    do_reset();
    for (int i = 0; i <= DEPTH; i++)
      if (i % 2 == 0) do_op("knight", 0, 1, 1, 18);
      else            do_op("knight", 0, 1, 18, 1);
    chk("full.depth", 256'(depth_count), 256'(DEPTH));

    do_reset();
    do_op("pawn_up",  0, 1, 12, 52);
    do_op("promo",    0, 1, 52, 60);
    chk("promo.sq60", 256'(board_flat[243:240]), 256'(PROMO ? 5 : 1));
    do_op("both",     1, 1, 60, 61);
    chk("both.sq52", 256'(board_flat[211:208]), 256'(1));

    // Reset while an accepted move sits in COMMIT must leave the opening position
    do_reset();
    @(negedge clk);
    move_valid = 1'b1; move_start = 6'd12; move_end = 6'd28;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst.board", board_flat, mflat());
    chk("midrst.state", 256'({ready, done, err, depth_count}), 256'({1'b1, 2'b00, CW'(0)}));
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 99) < 25) begin
        do_op("rnd_undo", 1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 63));
      end else begin
        s = $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0)
          for (int t = 0; t < 64 && mb[s] == 0; t++) s = $urandom_range(0, 63);
        e = ($urandom_range(0, 19) == 0) ? s : $urandom_range(0, 63);
        do_op("rnd_move", 0, 1, s, e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
